module_max_unpool: RTL and testbench
====================================

Name: module_max_unpool

Overview:
- 2x2 nearest-neighbour upsampler ("unpool") for the decoder side of the CNN datapath.
- Consumes a row-major pooled feature-map stream (IN_W x IN_H, signed) and emits a 2*IN_W x 2*IN_H stream.
- Each input pixel is duplicated horizontally; each input row is replayed once from an internal line buffer.
- Sits downstream of module_max_pool-style streams; provides ready_in backpressure because output rate is 4x input rate.

Parameters:
- DATA_W, 8, pixel width (signed two's complement)
- IN_W, 5, pooled row width in pixels (>=1)
- IN_H, 5, pooled rows per frame (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- valid_in  input  1  din valid; transfer occurs when valid_in && ready_in
- ready_in  output  1  block can accept a pixel this cycle
- din  input  DATA_W  signed input pixel
- valid_out  output  1  dout valid (no downstream backpressure)
- dout  output  DATA_W  signed output pixel
- last_out  output  1  high with the final output pixel of a frame

Behaviour:
- Reset (async, rst=1): state=ROW_A, col=0, row=0, ph=0; ready_in=0, valid_out=0, dout=0, last_out=0. Line buffer contents are don't-care. ready_in rises in the first cycle after rst deasserts.
- All outputs are registered. ready_in is a registered/state decode, not combinational from valid_in.
- ROW_A, ph=0:
  - ready_in=1.
  - On transfer: buffer[col] <= din, hold <= din.
  - Next cycle: valid_out=1, dout=din (copy 1), ph=1.
  - No transfer: valid_out=0; state unchanged (bubbles allowed).
- ROW_A, ph=1:
  - ready_in=0; valid_out=1, dout=hold (copy 2), ph<=0.
  - If col==IN_W-1: col<=0, go ROW_B. Else col<=col+1.
- Latency: 1 cycle from accept to first copy. With valid_in held high, output is gap-free: accept on every other cycle.
- valid_in while ready_in=0 is ignored; upstream holds din and valid_in until accepted.
- ROW_B:
  - ready_in=0.
  - Emits buffer[0],buffer[0],buffer[1],buffer[1],...,buffer[IN_W-1],buffer[IN_W-1].
  - 2*IN_W consecutive cycles, valid_out=1 every cycle, no gaps.
- After the last ROW_B pixel:
  - If row==IN_H-1: last_out=1 on that pixel; row<=0, col<=0, return to ROW_A (next frame).
  - Else: row<=row+1, return to ROW_A.
- ready_in rises in the cycle after the last ROW_B pixel; ROW_B never overlaps ROW_A acceptance.
- Counters: col is clog2(IN_W) bits wide, row is clog2(IN_H) bits wide (minimum 1 bit each). Both wrap exactly at IN_W-1 / IN_H-1; no other terminal values.
- Per frame: exactly IN_W*IN_H accepts, 4*IN_W*IN_H valid_out cycles, and exactly one last_out pulse.
- Data passes unmodified; no arithmetic and no sign change.
- IN_W=1: ROW_A is 2 cycles, ROW_B is 2 cycles. IN_H=1: last_out asserts on the first ROW_B pass.
- Mid-frame rst: immediate clear to the reset state; no partial frame is completed or flushed.

Optional Feature:
- Macro: UNPOOL_ZERO_FILL_EN
- Defined: bed-of-nails unpool.
  - ROW_A copy 2 outputs 0 instead of hold.
  - ROW_B outputs 0 for all 2*IN_W pixels; the line buffer is not written or read and may be removed.
  - Timing, valid_out, ready_in and last_out are identical to the default.
- Undefined (default): nearest-neighbour replication as described in Behaviour.

Test Plan:
- Reset: hold rst=1 with valid_in=1 → ready_in=0, valid_out=0, dout=0, last_out=0; ready_in=1 in the cycle after release.
- Streaming ramp, IN_W=5, IN_H=5, valid_in=1 continuous, din cycling 1..10 per accept → row 0 outputs 1,1,2,2,3,3,4,4,5,5 twice. Row 1 outputs 6,6,...,10,10 twice. 100 valid_out cycles per frame with one last_out on pixel 100. Accepts occur only on ready_in=1.
- Bubbles: valid_in toggled randomly → identical output sequence; gaps appear in ROW_A only; ROW_B has 10 back-to-back valids.
- Signed extremes: din=-128, 127, -1, 0, 1 → same values on dout; no sign corruption on buffer replay.
- Mid-frame reset: assert rst during ROW_B of row 2 → outputs cleared immediately; next frame starts at row 0, col 0; last_out after 100 outputs.
- UNPOOL_ZERO_FILL_EN defined, same ramp → row 0 outputs 1,0,2,0,3,0,4,0,5,0 then ten 0s; timing identical to default.

Source files
------------

// File: rtl/module_max_unpool_if.sv
// -----------------------------------------------------------------------------
// module_max_unpool_if
// Stream bundle for the 2x2 unpool block.
//   valid_in  : upstream pixel valid
//   ready_in  : block accepts a pixel this cycle
//   din       : signed input pixel, DATA_W bits
//   valid_out : output pixel valid (no downstream backpressure)
//   dout      : signed output pixel, DATA_W bits
//   last_out  : final output pixel of a frame
// Modports: master = upstream/environment side, slave = unpool block side.
// -----------------------------------------------------------------------------
interface module_max_unpool_if #(
    parameter int DATA_W = 8
);
    logic                     valid_in;
    logic                     ready_in;
    logic signed [DATA_W-1:0] din;
    logic                     valid_out;
    logic signed [DATA_W-1:0] dout;
    logic                     last_out;

    modport master (
        output valid_in, din,
        input  ready_in, valid_out, dout, last_out
    );

    modport slave (
        input  valid_in, din,
        output ready_in, valid_out, dout, last_out
    );
endinterface

// File: rtl/module_max_unpool.sv
// -----------------------------------------------------------------------------
// module_max_unpool
// 2x2 upsampler for a row-major IN_W x IN_H signed pixel stream. Each accepted
// pixel is emitted twice (ROW_A), then the whole row is replayed from a line
// buffer with every pixel doubled again (ROW_B), giving a 2*IN_W x 2*IN_H frame.
// Because output rate is 4x input rate, ready_in throttles the upstream.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : module_max_unpool_if.slave (valid_in/ready_in/din in,
//          valid_out/dout/last_out out); all outputs are registered.
//
// Build option:
//   UNPOOL_ZERO_FILL_EN : bed-of-nails unpool. Second ROW_A copy and the whole
//   ROW_B replay are zeros; the line buffer disappears. Timing is unchanged.
// -----------------------------------------------------------------------------
module module_max_unpool #(
    parameter int DATA_W = 8,
    parameter int IN_W   = 5,
    parameter int IN_H   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    module_max_unpool_if.slave   bus
);
    localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);

    // ROW_A: accept and double live pixels; ROW_B: replay the buffered row.
    typedef enum logic {ROW_A, ROW_B} state_t;

    state_t                   r_state;
    logic [COL_W-1:0]         r_col;   // pixel index in ROW_A, replay index in ROW_B
    logic [ROW_W-1:0]         r_row;
    logic                     r_ph;    // which of the two copies is being produced
    logic                     r_ready;
    logic                     r_valid;
    logic signed [DATA_W-1:0] r_dout;
    logic                     r_last;

    state_t                   w_state_nx;
    logic [COL_W-1:0]         w_col_nx;
    logic [ROW_W-1:0]         w_row_nx;
    logic                     w_ph_nx;
    logic                     w_ready_nx;
    logic                     w_valid_nx;
    logic signed [DATA_W-1:0] w_dout_nx;
    logic                     w_last_nx;
    logic                     w_xfer;
    logic                     w_accept;

    // ready_in is registered, so a transfer is simply valid_in against it.
    assign w_xfer   = bus.valid_in && r_ready;
    assign w_accept = (r_state == ROW_A) && !r_ph && w_xfer;

`ifndef UNPOOL_ZERO_FILL_EN
    logic signed [DATA_W-1:0] r_hold;
    logic signed [DATA_W-1:0] r_buf [IN_W];

    // NOTE: pure storage with no reset; its contents are never observed before
    // being written, so a reset would only add fan-out and block RAM inference.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_col] <= bus.din;
            r_hold       <= bus.din;
        end
    end
`endif

    // NOTE: every register uses non-blocking assignment so all of them sample
    // the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ROW_A;
            r_col   <= '0;
            r_row   <= '0;
            r_ph    <= 1'b0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_dout  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_col   <= w_col_nx;
            r_row   <= w_row_nx;
            r_ph    <= w_ph_nx;
            r_ready <= w_ready_nx;
            r_valid <= w_valid_nx;
            r_dout  <= w_dout_nx;
            r_last  <= w_last_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        w_state_nx = r_state;
        w_col_nx   = r_col;
        w_row_nx   = r_row;
        w_ph_nx    = r_ph;
        unique case (r_state)
            ROW_A: begin
                if (!r_ph) begin
                    if (w_xfer) w_ph_nx = 1'b1;
                end else begin
                    w_ph_nx = 1'b0;
                    if (r_col == COL_LAST) begin
                        w_col_nx   = '0;
                        w_state_nx = ROW_B;
                    end else begin
                        w_col_nx = r_col + COL_W'(1);
                    end
                end
            end
            ROW_B: begin
                w_ph_nx = ~r_ph;
                if (r_ph) begin
                    if (r_col == COL_LAST) begin
                        w_col_nx   = '0;
                        w_state_nx = ROW_A;
                        w_row_nx   = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
                    end else begin
                        w_col_nx = r_col + COL_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Output logic: values loaded into the output registers at the next edge.
    always_comb begin
        // Ready exactly when the coming cycle is a ROW_A first-copy slot.
        w_ready_nx = (w_state_nx == ROW_A) && !w_ph_nx;
        w_valid_nx = 1'b0;
        w_dout_nx  = '0;
        w_last_nx  = 1'b0;
        unique case (r_state)
            ROW_A: begin
                if (!r_ph) begin
                    if (w_xfer) begin
                        w_valid_nx = 1'b1;
                        w_dout_nx  = bus.din;
                    end
                end else begin
                    w_valid_nx = 1'b1;
`ifndef UNPOOL_ZERO_FILL_EN
                    w_dout_nx  = r_hold;
`endif
                end
            end
            ROW_B: begin
                w_valid_nx = 1'b1;
`ifndef UNPOOL_ZERO_FILL_EN
                w_dout_nx  = r_buf[r_col];
`endif
                w_last_nx  = r_ph && (r_col == COL_LAST) && (r_row == ROW_LAST);
            end
            default: ;
        endcase
    end

    assign bus.ready_in  = r_ready;
    assign bus.valid_out = r_valid;
    assign bus.dout      = r_dout;
    assign bus.last_out  = r_last;
endmodule

// File: tb/tb_module_max_unpool.sv
// -----------------------------------------------------------------------------
// tb_module_max_unpool
// Scoreboard bench: every accepted pixel pushes its expected outputs into a
// queue, computed from the frame geometry (two copies per pixel, whole row
// replayed after the row completes); an independent monitor pops on valid_out.
// -----------------------------------------------------------------------------
module tb_module_max_unpool;
    localparam int DATA_W = 8;
    localparam int IN_W   = 5;
    localparam int IN_H   = 5;
    localparam int NPIX   = IN_W * IN_H;

    typedef struct {
        logic signed [DATA_W-1:0] d;
        logic                     last;
        logic                     b2b;   // must directly follow another valid
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    module_max_unpool_if #(.DATA_W(DATA_W)) bus ();

    module_max_unpool #(.DATA_W(DATA_W), .IN_W(IN_W), .IN_H(IN_H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // Reference model state: position in the pooled frame and the current row.
    int                       m_col = 0;
    int                       m_row = 0;
    logic signed [DATA_W-1:0] m_line [IN_W];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [DATA_W-1:0] fill(input logic signed [DATA_W-1:0] d);
`ifdef UNPOOL_ZERO_FILL_EN
        return '0;
`else
        return d;
`endif
    endfunction

    task automatic model_accept(input logic signed [DATA_W-1:0] d);
        exp_q.push_back('{d: d, last: 1'b0, b2b: 1'b0});
        exp_q.push_back('{d: fill(d), last: 1'b0, b2b: 1'b1});
        m_line[m_col] = d;
        if (m_col == IN_W - 1) begin
            for (int c = 0; c < IN_W; c++) begin
                for (int k = 0; k < 2; k++) begin
                    exp_q.push_back('{d: fill(m_line[c]),
                                      last: (m_row == IN_H - 1) && (c == IN_W - 1) && (k == 1),
                                      b2b: 1'b1});
                end
            end
            m_col = 0;
            m_row = (m_row == IN_H - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic drive_pixel(input logic signed [DATA_W-1:0] d, input bit bubble);
        int waited = 0;
        if (bubble) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.valid_in = 1'b0;
                @(negedge clk);
            end
        end
        bus.valid_in = 1'b1;
        bus.din      = d;
        while (!bus.ready_in) begin
            @(negedge clk);
            waited++;
            if (waited > 4 * IN_W + 20) begin
                n_tests++;
                n_fail++;
                $display("FAIL ready_timeout: got ready_in=0 expected 1 within %0d cycles", waited);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $fatal(1, "ready_in never rose");
            end
        end
        model_accept(d);
        @(negedge clk);
    endtask

    // mode 0: ramp 1..10, 1: random, 2: signed extremes
    task automatic send_pixels(input int n, input int mode, input bit bubble);
        logic signed [DATA_W-1:0] ext [5];
        logic signed [DATA_W-1:0] d;
        ext[0] = -8'sd128; ext[1] = 8'sd127; ext[2] = -8'sd1; ext[3] = 8'sd0; ext[4] = 8'sd1;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       d = DATA_W'((i % 10) + 1);
                1:       d = DATA_W'($urandom);
                default: d = ext[i % 5];
            endcase
            drive_pixel(d, bubble);
        end
        bus.valid_in = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every output pixel.
    exp_t mon_e;
    bit   prev_v  = 1'b0;
    int   out_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v  = 1'b0;
            out_cnt = 0;
        end else begin
            if (bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid_out", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dout", $signed(bus.dout), $signed(mon_e.d));
                    check("last_out", {31'd0, bus.last_out}, {31'd0, mon_e.last});
                    if (mon_e.b2b) check("gap_free", {31'd0, prev_v}, 1);
                end
                out_cnt++;
                if (bus.last_out) begin
                    check("frame_len", out_cnt, 4 * NPIX);
                    out_cnt = 0;
                end
            end
            prev_v = bus.valid_out;
        end
    end

    initial begin
        int waited;
        bus.valid_in = 1'b1;
        bus.din      = 8'sh55;

        // Reset held with valid_in high: everything quiet.
        repeat (3) @(negedge clk);
        check("rst_ready_in", {31'd0, bus.ready_in}, 0);
        check("rst_valid_out", {31'd0, bus.valid_out}, 0);
        check("rst_dout", $signed(bus.dout), 0);
        check("rst_last_out", {31'd0, bus.last_out}, 0);
        bus.valid_in = 1'b0;
        rst = 1'b0;
        check("ready_before_edge", {31'd0, bus.ready_in}, 0);
        @(posedge clk);
        #1;
        check("ready_after_release", {31'd0, bus.ready_in}, 1);
        @(negedge clk);

        send_pixels(NPIX, 0, 1'b0);   // continuous ramp
        send_pixels(NPIX, 0, 1'b1);   // ramp with bubbles
        send_pixels(NPIX, 1, 1'b1);   // random data, random bubbles
        send_pixels(NPIX, 2, 1'b0);   // signed extremes

        // Mid-frame reset during the ROW_B replay of row 2.
        send_pixels(3 * IN_W, 1, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid_out", {31'd0, bus.valid_out}, 0);
        check("midrst_dout", $signed(bus.dout), 0);
        check("midrst_last_out", {31'd0, bus.last_out}, 0);
        check("midrst_ready_in", {31'd0, bus.ready_in}, 0);
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send_pixels(NPIX, 0, 1'b1);   // fresh frame from row 0, col 0
        send_pixels(NPIX, 1, 1'b0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("idle_valid_out", {31'd0, bus.valid_out}, 0);
        check("idle_ready_in", {31'd0, bus.ready_in}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
